// File: rtl/soc_evt_bridge_pkg.sv
// Shared helpers for the SoC-to-cluster event bridge (source side).
// The slot word {chan_id, payload} is declared per instance from CH_W and EVNT_WIDTH.
package soc_evt_bridge_pkg;

  localparam int unsigned ROT_MAX_W = 64;
  localparam int unsigned ROT_IDX_W = 6;

  // Channel-id width; a single channel still carries a 1-bit id of 0.
  function automatic int unsigned ch_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                 input int unsigned          n);
    logic [ROT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < n) begin
        if (i + 1 == n) r[0] = v[ROT_IDX_W'(i)];
        else            r[ROT_IDX_W'(i + 1)] = v[ROT_IDX_W'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter: one-hot grant plus index, priority pointer advances past the winner.
module soc_evt_rr_arb
  import soc_evt_bridge_pkg::*;
#(
  parameter  int unsigned N_CH  = 3,
  localparam int unsigned IDX_W = ch_w(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_CH-1:0]  req_i,
  input  logic             en_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int unsigned      idx;

  // Search requests starting at the priority pointer; gate the grant with enable.
  always_comb begin
    found     = 1'b0;
    idx       = '0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = (32'(ptr_q) + off) % N_CH;
      if (!found && req_i[IDX_W'(idx)]) begin
        found     = 1'b1;
        gnt_idx_o = IDX_W'(idx);
      end
    end
    gnt_vld_o = found && en_i;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  // Priority pointer moves to the channel after the winner; holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_vld_o) begin
      ptr_q <= IDX_W'((32'(gnt_idx_o) + 1) % N_CH);
    end
  end

endmodule

// File: rtl/soc_evt_bridge_tx.sv
// Source side of the SoC-to-cluster event crossing: arbitrates N_CH channels into a
// token-addressed slot ring and stalls on the synchronised consumer read pointer.
// Optional statistics counters are built when SOC_EVT_BRIDGE_STATS_EN is defined.
module soc_evt_bridge_tx
  import soc_evt_bridge_pkg::*;
#(
  parameter  int unsigned N_CH        = 3,
  parameter  int unsigned DEPTH       = 8,
  parameter  int unsigned EVNT_WIDTH  = 8,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W        = ch_w(N_CH),
  localparam int unsigned SLOT_W      = CH_W + EVNT_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_CH-1:0]            evt_valid_i,
  input  logic [N_CH*EVNT_WIDTH-1:0] evt_data_i,
  output logic [N_CH-1:0]            evt_ack_o,
  output logic [DEPTH-1:0]           evt_wt_o,
  output logic [DEPTH*SLOT_W-1:0]    evt_da_o,
  input  logic [DEPTH-1:0]           evt_rp_i,
`ifdef SOC_EVT_BRIDGE_STATS_EN
  output logic [15:0]                stat_evt_cnt_o,
  output logic [15:0]                stat_stall_cnt_o,
`endif
  output logic                       full_o
);

  typedef struct packed {
    logic [CH_W-1:0]       chan_id;
    logic [EVNT_WIDTH-1:0] payload;
  } slot_t;

  logic [SYNC_STAGES-1:0][DEPTH-1:0] sync_q;
  logic [DEPTH-1:0]                  rp_sync;
  logic [DEPTH-1:0]                  wt_q;
  logic [DEPTH-1:0]                  wt_next;
  slot_t [DEPTH-1:0]                 slot_q;
  slot_t                             wr_slot;
  logic                              full;
  logic [N_CH-1:0]                   gnt;
  logic [CH_W-1:0]                   gnt_idx;
  logic                              gnt_vld;

  // Read-pointer synchroniser; reset to slot 0 so X during reset never reaches full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{DEPTH'(1)}};
    end else begin
      sync_q[0] <= evt_rp_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign rp_sync = sync_q[SYNC_STAGES-1];
  assign wt_next = DEPTH'(rotl1(ROT_MAX_W'(wt_q), DEPTH));
  assign full    = (wt_next == rp_sync);

  soc_evt_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (evt_valid_i),
    .en_i      (!full),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Select the granted channel's payload and tag it with its channel id.
  always_comb begin
    wr_slot = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) begin
        wr_slot.chan_id = gnt_idx;
        wr_slot.payload = evt_data_i[c*EVNT_WIDTH +: EVNT_WIDTH];
      end
    end
  end

  // Write only the slot under the token, then advance the token on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wt_q   <= DEPTH'(1);
      slot_q <= '0;
    end else if (gnt_vld) begin
      wt_q <= wt_next;
      for (int s = 0; s < DEPTH; s++) begin
        if (wt_q[s]) slot_q[s] <= wr_slot;
      end
    end
  end

  assign evt_ack_o = gnt;
  assign evt_wt_o  = wt_q;
  assign evt_da_o  = slot_q;
  assign full_o    = full;

`ifdef SOC_EVT_BRIDGE_STATS_EN
  logic [15:0] evt_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counts of accepted events and of cycles stalled by a full ring.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt_vld && evt_cnt_q != 16'hFFFF) evt_cnt_q <= evt_cnt_q + 16'd1;
      if ((|evt_valid_i) && full && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_evt_cnt_o   = evt_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule
